// File: rtl/light_hash_seq_ctrl.sv
// light_hash_seq_ctrl
//   Sequencer in front of the light_hash core. Incoming message bytes are
//   buffered in a small FIFO. The controller then issues the core's command
//   sequence: HEAD, one MESSAGE per byte, then TAIL. Every command is a
//   one-cycle pulse followed by at least one gap cycle. The 64-bit digest
//   is captured and offered on a valid/ready output port.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last
//                              input byte stream (s_last marks final byte)
//   d_valid/d_ready/d_data     captured digest output
//   core_message_valid, core_state, core_message_byte
//                              command pulse to the core
//                              (state 00 head, 10 message, 01 tail, 11 idle)
//   core_next_byte             core is ready for the next command
//   core_digest, core_digest_ready
//                              digest result from the core
//   busy                       controller is not idle
//   err / err_clr              sticky timeout flag and its clear pulse
module light_hash_seq_ctrl #(
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [63:0] d_data,
    output logic        core_message_valid,
    output logic [1:0]  core_state,
    output logic [7:0]  core_message_byte,
    input  logic        core_next_byte,
    input  logic [63:0] core_digest,
    input  logic        core_digest_ready,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] CMD_HEAD = 2'b00;
    localparam logic [1:0] CMD_MSG  = 2'b10;
    localparam logic [1:0] CMD_TAIL = 2'b01;
    localparam logic [1:0] CMD_NONE = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HEAD,
        ST_HGAP,
        ST_WRDY,
        ST_SEND,
        ST_MGAP,
        ST_WTAIL,
        ST_TAIL,
        ST_WDIG,
        ST_OUT,
        ST_DRAIN
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO, entries are {last, data}
    // ------------------------------------------------------------------
    logic [8:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          s_ready_reg;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic [8:0]    head_entry;

    state_t        state_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic          tmo_run;
    logic          tmo_hit;
    logic          last_reg;
    logic          cmv_reg;
    logic [1:0]    cst_reg;
    logic [7:0]    cbyte_reg;
    logic          d_valid_reg;
    logic [63:0]   d_data_reg;
    logic          err_reg;

    assign fifo_empty = (count_reg == '0);
    assign fifo_push  = s_valid && s_ready_reg;
    assign head_entry = fifo_mem[rd_ptr_reg];

    // The FSM is the only consumer: normal sends and the discard path.
    assign fifo_pop = !fifo_empty &&
                      (((state_reg == ST_WRDY) && core_next_byte) ||
                       (state_reg == ST_DRAIN));

    assign count_next = count_reg + CW'(fifo_push) - CW'(fifo_pop);

    always_ff @(posedge clk) begin
        if (rst_n && fifo_push) begin
            fifo_mem[wr_ptr_reg] <= {s_last, s_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            s_ready_reg <= 1'b0;
        end else begin
            if (fifo_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg   <= count_next;
            // Registered ready tracks the count the next cycle will see.
            s_ready_reg <= (count_next != CW'(FIFO_DEPTH));
        end
    end

    // ------------------------------------------------------------------
    // Timeout: only counts while actually waiting on the core. An empty
    // FIFO in WRDY with the core ready is starvation, not a stall.
    // ------------------------------------------------------------------
    assign tmo_run = (((state_reg == ST_WRDY) || (state_reg == ST_WTAIL)) && !core_next_byte) ||
                     ((state_reg == ST_WDIG) && !core_digest_ready);
    assign tmo_hit = tmo_run && (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));

    // ------------------------------------------------------------------
    // Sequencer FSM with registered command and digest outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            tmo_cnt_reg <= '0;
            last_reg    <= 1'b0;
            cmv_reg     <= 1'b0;
            cst_reg     <= CMD_NONE;
            cbyte_reg   <= 8'd0;
            d_valid_reg <= 1'b0;
            d_data_reg  <= 64'd0;
            err_reg     <= 1'b0;
        end else begin
            // A timeout in the same cycle as a clear leaves the flag set.
            err_reg <= (err_reg && !err_clr) || tmo_hit;

            if (tmo_run) begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_reg <= ST_HEAD;
                        cmv_reg   <= 1'b1;
                        cst_reg   <= CMD_HEAD;
                        cbyte_reg <= 8'd0;
                        last_reg  <= 1'b0;
                    end
                end
                ST_HEAD: begin
                    state_reg <= ST_HGAP;
                    cmv_reg   <= 1'b0;
                    cst_reg   <= CMD_NONE;
                end
                ST_HGAP: begin
                    state_reg <= ST_WRDY;
                end
                ST_WRDY: begin
                    if (core_next_byte && !fifo_empty) begin
                        state_reg   <= ST_SEND;
                        cmv_reg     <= 1'b1;
                        cst_reg     <= CMD_MSG;
                        cbyte_reg   <= head_entry[7:0];
                        last_reg    <= head_entry[8];
                        tmo_cnt_reg <= '0;
                    end else if (tmo_hit) begin
                        // Remaining bytes of the message must be discarded.
                        state_reg   <= last_reg ? ST_IDLE : ST_DRAIN;
                        tmo_cnt_reg <= '0;
                    end
                end
                ST_SEND: begin
                    state_reg <= ST_MGAP;
                    cmv_reg   <= 1'b0;
                    cst_reg   <= CMD_NONE;
                end
                ST_MGAP: begin
                    state_reg <= last_reg ? ST_WTAIL : ST_WRDY;
                end
                ST_WTAIL: begin
                    if (core_next_byte) begin
                        state_reg   <= ST_TAIL;
                        cmv_reg     <= 1'b1;
                        cst_reg     <= CMD_TAIL;
                        tmo_cnt_reg <= '0;
                    end else if (tmo_hit) begin
                        state_reg   <= ST_IDLE;
                        tmo_cnt_reg <= '0;
                    end
                end
                ST_TAIL: begin
                    state_reg <= ST_WDIG;
                    cmv_reg   <= 1'b0;
                    cst_reg   <= CMD_NONE;
                end
                ST_WDIG: begin
                    if (core_digest_ready) begin
                        state_reg   <= ST_OUT;
                        d_data_reg  <= core_digest;
                        d_valid_reg <= 1'b1;
                        tmo_cnt_reg <= '0;
                    end else if (tmo_hit) begin
                        state_reg   <= ST_IDLE;
                        tmo_cnt_reg <= '0;
                    end
                end
                ST_OUT: begin
                    if (d_ready) begin
                        state_reg   <= ST_IDLE;
                        d_valid_reg <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!fifo_empty && head_entry[8]) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready            = s_ready_reg;
    assign core_message_valid = cmv_reg;
    assign core_state         = cst_reg;
    assign core_message_byte  = cbyte_reg;
    assign d_valid            = d_valid_reg;
    assign d_data             = d_data_reg;
    assign err                = err_reg;
    assign busy               = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_light_hash_seq_ctrl.sv
// Testbench for light_hash_seq_ctrl. A behavioural stub stands in for the
// light_hash core: it folds received MESSAGE bytes into an FNV-1a hash and
// reports it after TAIL. The expected digest of every message is computed
// directly from the bytes the bench sends.
`timescale 1ns/1ps
module tb_light_hash_seq_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 64;
    localparam int LIM   = 400;
    localparam logic [63:0] FNV_OFF   = 64'hcbf29ce484222325;
    localparam logic [63:0] FNV_PRIME = 64'h00000100000001b3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'd0;
    logic        s_last = 1'b0;
    logic        d_valid;
    logic        d_ready;
    logic [63:0] d_data;
    logic        cmv;
    logic [1:0]  cst;
    logic [7:0]  cbyte;
    logic        core_next_byte;
    logic [63:0] core_digest;
    logic        core_digest_ready;
    logic        busy;
    logic        err;
    logic        err_clr = 1'b0;

    logic d_ready_fix = 1'b1;
    logic d_ready_rnd = 1'b0;
    logic rnd_mode = 1'b0;
    logic stub_hold = 1'b0;
    int   stub_lat = 1;

    int vectors = 0;
    int miscompares = 0;
    int push_cnt = 0;

    logic [7:0]  mbuf [64];
    int          mlen = 0;
    logic [63:0] exp_q [$];
    logic [63:0] got_q [$];

    always #5 clk = ~clk;

    light_hash_seq_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
        .core_message_valid(cmv), .core_state(cst), .core_message_byte(cbyte),
        .core_next_byte(core_next_byte), .core_digest(core_digest),
        .core_digest_ready(core_digest_ready),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    assign d_ready = rnd_mode ? d_ready_rnd : d_ready_fix;
    always @(posedge clk) d_ready_rnd <= 1'($urandom_range(0, 1));

    function automatic logic [63:0] fnv_step(input logic [63:0] h, input logic [7:0] b);
        return (h ^ {56'd0, b}) * FNV_PRIME;
    endfunction

    function automatic logic [63:0] ref_digest();
        logic [63:0] h = FNV_OFF;
        for (int i = 0; i < mlen; i++) h = fnv_step(h, mbuf[i]);
        return h;
    endfunction

    // ---------------- stub core ----------------
    logic [63:0] acc;
    int          busy_cnt;
    int          dig_cnt;
    logic        dig_rdy;

    always @(posedge clk) begin
        if (!rst_n) begin
            acc <= FNV_OFF; busy_cnt <= 0; dig_cnt <= 0; dig_rdy <= 1'b0;
        end else begin
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            if (dig_cnt > 0) begin
                dig_cnt <= dig_cnt - 1;
                if (dig_cnt == 1) dig_rdy <= 1'b1;
            end
            if (cmv) begin
                busy_cnt <= stub_lat;
                case (cst)
                    2'b00: begin acc <= FNV_OFF; dig_rdy <= 1'b0; end
                    2'b10: acc <= fnv_step(acc, cbyte);
                    2'b01: dig_cnt <= 3;
                    default: ;
                endcase
            end
        end
    end
    assign core_next_byte    = !stub_hold && (busy_cnt == 0);
    assign core_digest_ready = dig_rdy;
    assign core_digest       = dig_rdy ? acc : ~acc;

    // ---------------- monitor ----------------
    int   cyc = 0, head_cnt = 0, msg_cnt = 0, proto_bad = 0, dv_cnt = 0;
    int   min_gap = 1000, last_msg_cyc = -1;
    logic prev_valid = 1'b0, prev_dv = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (cmv) begin
                if (prev_valid) proto_bad++;
                if (cst == 2'b00) begin head_cnt++; last_msg_cyc = -1; end
                if (cst == 2'b10) begin
                    if (last_msg_cyc >= 0 && (cyc - last_msg_cyc) < min_gap) min_gap = cyc - last_msg_cyc;
                    last_msg_cyc = cyc;
                    msg_cnt++;
                end
            end else if (cst !== 2'b11) begin
                proto_bad++;
            end
            if (d_valid && !prev_dv) dv_cnt++;
            if (d_valid && d_ready) got_q.push_back(d_data);
        end
        prev_valid = cmv;
        prev_dv    = d_valid;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic load_str(input string s);
        mlen = s.len();
        for (int i = 0; i < mlen; i++) mbuf[i] = s[i];
    endtask

    task automatic push_byte(input logic [7:0] b, input logic l);
        int n = 0;
        if (rnd_mode) repeat ($urandom_range(0, 2)) tick();
        s_valid = 1'b1; s_data = b; s_last = l;
        while (s_ready !== 1'b1 && n < LIM) begin tick(); n++; end
        check("push_wait", 64'(n < LIM), 64'd1);
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        push_cnt++;
    endtask

    task automatic send_buf(input logic expd);
        if (expd) exp_q.push_back(ref_digest());
        for (int i = 0; i < mlen; i++) push_byte(mbuf[i], (i == mlen - 1));
    endtask

    task automatic wait_digests(input string tag);
        int n = 0;
        while (got_q.size() != exp_q.size() && n < 3000) begin tick(); n++; end
        check(tag, 64'(got_q.size()), 64'(exp_q.size()));
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_s_ready"}, 64'(s_ready), 64'd0);
        check({pfx, "_cmv"},     64'(cmv), 64'd0);
        check({pfx, "_cstate"},  64'(cst), 64'd3);
        check({pfx, "_cbyte"},   64'(cbyte), 64'd0);
        check({pfx, "_d_valid"}, 64'(d_valid), 64'd0);
        check({pfx, "_d_data"},  d_data, 64'd0);
        check({pfx, "_busy"},    64'(busy), 64'd0);
        check({pfx, "_err"},     64'(err), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int n, bad, h0, dv0, m0;
        logic [63:0] exp_a;

        // Reset values
        rst_n = 1'b0;
        tick(); tick();
        check_reset_values("rst");
        rst_n = 1'b1;
        tick();
        check("rst_release_s_ready", 64'(s_ready), 64'd1);

        // Single-byte message: HEAD appears two cycles after the write
        mlen = 1; mbuf[0] = 8'h5a;
        exp_q.push_back(ref_digest());
        s_valid = 1'b1; s_data = 8'h5a; s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        check("lat_cycle1_no_cmd", 64'(cmv), 64'd0);
        tick();
        check("lat_cycle2_head", 64'({cmv, cst}), 64'({1'b1, 2'b00}));
        wait_digests("t1_single_byte");

        load_str("H4rdw4r3_Tr0j4n");
        send_buf(1'b1);
        wait_digests("t1_trojan");

        // Two messages back to back
        load_str("3.141592653589793238");
        send_buf(1'b1);
        load_str("AlessandroAndGiacomo");
        send_buf(1'b1);
        wait_digests("t2_back_to_back");

        // Stalled digest consumer; next message queues but must not start
        d_ready_fix = 1'b0;
        load_str("SlowConsumerA");
        exp_a = ref_digest();
        send_buf(1'b1);
        n = 0;
        while (d_valid !== 1'b1 && n < LIM) begin tick(); n++; end
        check("t3_d_valid_rise", 64'(d_valid), 64'd1);
        h0 = head_cnt;
        bad = 0;
        load_str("NextInLine");
        fork
            send_buf(1'b1);
            begin
                repeat (50) begin
                    tick();
                    if (d_valid !== 1'b1 || d_data !== exp_a) bad++;
                end
                check("t3_hold_stable", 64'(bad), 64'd0);
                check("t3_no_head_in_out", 64'(head_cnt), 64'(h0));
                check("t3_busy_in_out", 64'(busy), 64'd1);
                d_ready_fix = 1'b1;
                tick();
                check("t3_d_valid_drop", 64'(d_valid), 64'd0);
            end
        join
        wait_digests("t3_digests");

        // Core stalls: FIFO fills, back-pressure, then drains in order
        stub_hold = 1'b1;
        push_cnt = 0;
        load_str("FifoBackPressure");
        fork
            send_buf(1'b1);
            begin
                repeat (30) tick();
                check("t4_pushes_accepted", 64'(push_cnt), 64'(DEPTH));
                check("t4_s_ready_low", 64'(s_ready), 64'd0);
                repeat (10) tick();
                stub_hold = 1'b0;
            end
        join
        wait_digests("t4_digests");

        // Core never ready: timeout, drain, sticky err
        stub_hold = 1'b1;
        dv0 = dv_cnt;
        load_str("TimeoutVictim");
        fork
            send_buf(1'b0);
            begin
                n = 0;
                while (!(cmv === 1'b1 && cst === 2'b00) && n < LIM) begin tick(); n++; end
                check("t5_head_seen", 64'(n < LIM), 64'd1);
                repeat (TMO + 1) tick();
                check("t5_err_before_timeout", 64'(err), 64'd0);
                err_clr = 1'b1;
                tick();
                err_clr = 1'b0;
                check("t5_timeout_beats_clr", 64'(err), 64'd1);
                check("t5_busy_draining", 64'(busy), 64'd1);
            end
        join
        n = 0;
        while (busy !== 1'b0 && n < LIM) begin tick(); n++; end
        check("t5_busy_clear", 64'(busy), 64'd0);
        repeat (10) tick();
        check("t5_no_digest", 64'(dv_cnt), 64'(dv0));
        check("t5_err_sticky", 64'(err), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_err_cleared", 64'(err), 64'd0);
        stub_hold = 1'b0;
        load_str("AfterDrain");
        send_buf(1'b1);
        wait_digests("t5_after_drain");

        // Reset in the middle of a message
        load_str("InterruptedMessage");
        m0 = msg_cnt;
        for (int i = 0; i < 6; i++) push_byte(mbuf[i], 1'b0);
        n = 0;
        while (msg_cnt < m0 + 2 && n < LIM) begin tick(); n++; end
        check("t6_mid_message", 64'(msg_cnt >= m0 + 2), 64'd1);
        rst_n = 1'b0;
        tick();
        check_reset_values("t6_rst");
        rst_n = 1'b1;
        tick();
        load_str("AlessandroandGiacomo");
        send_buf(1'b1);
        wait_digests("t6_after_reset");

        // Randomised messages, core latency and consumer back-pressure
        rnd_mode = 1'b1;
        for (int m = 0; m < 6; m++) begin
            mlen = $urandom_range(1, 12);
            stub_lat = $urandom_range(1, 4);
            for (int i = 0; i < mlen; i++) mbuf[i] = 8'($urandom);
            send_buf(1'b1);
        end
        wait_digests("rnd_digests");
        rnd_mode = 1'b0;
        repeat (5) tick();

        check("protocol_violations", 64'(proto_bad), 64'd0);
        check("min_cycles_per_byte", 64'(min_gap), 64'd3);
        check("digest_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("digest_%0d", i), got_q[i], exp_q[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
